// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the Nexys2 SRAM exerciser.
// The wait states WRW/RDW are only reachable when SRAM_WAIT_EN is defined.
package sram_ctrl_pkg;

  localparam int ADR_W_DEF = 19;
  localparam int DAT_W_DEF = 16;

  localparam int BTN_ADR = 0;
  localparam int BTN_WR  = 1;
  localparam int BTN_RD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR1,
    ST_WRW,
    ST_WR2,
    ST_RD1,
    ST_RDW,
    ST_RD2
  } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response handshake between the exerciser front end and the
// asynchronous-SRAM controller.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
);

  logic             start_wr;
  logic             start_rd;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] wdata;
  logic [DAT_W-1:0] rdata;
  logic             rvalid;
  logic             ready;

  modport master (
    output start_wr, start_rd, adr, wdata,
    input  rdata, rvalid, ready
  );

  modport slave (
    input  start_wr, start_rd, adr, wdata,
    output rdata, rvalid, ready
  );

endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: FSM, registered active-low strobes and
// the shared data-bus tristate.
// Build option: SRAM_WAIT_EN inserts one wait state after WR1 and RD1.
// rvalid/rdata are combinational in RD2: the consumer captures the bus on
// the same edge that leaves RD2.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  sram_ctrl_if.slave       ctl,
  output logic [ADR_W-1:0] sram_adr,
  inout  wire  [DAT_W-1:0] sram_dat,
  output logic             sram_we_n,
  output logic             sram_oe_n,
  output logic             sram_ce_n
);

  state_t           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdata_q, wdata_d;
  logic             drive_q, drive_d;
  logic             we_n_q, we_n_d;
  logic             oe_n_q, oe_n_d;
  logic             ce_n_q, ce_n_d;

  // Next state, access latching, and strobe levels for the state being entered
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ctl.start_wr) begin
          state_d = ST_WR1;
          adr_d   = ctl.adr;
          wdata_d = ctl.wdata;
        end else if (ctl.start_rd) begin
          state_d = ST_RD1;
          adr_d   = ctl.adr;
        end
      end
`ifdef SRAM_WAIT_EN
      ST_WR1:  state_d = ST_WRW;
      ST_RD1:  state_d = ST_RDW;
`else
      ST_WR1:  state_d = ST_WR2;
      ST_RD1:  state_d = ST_RD2;
`endif
      ST_WRW:  state_d = ST_WR2;
      ST_WR2:  state_d = ST_IDLE;
      ST_RDW:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ce_n_d  = (state_d == ST_IDLE);
    we_n_d  = !(state_d inside {ST_WR1, ST_WRW});
    oe_n_d  = !(state_d inside {ST_RD1, ST_RDW, ST_RD2});
    drive_d = (state_d inside {ST_WR1, ST_WRW, ST_WR2});
  end

  // State and SRAM pin registers; reset forces idle and releases the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      drive_q <= drive_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      ce_n_q  <= ce_n_d;
    end
  end

  assign sram_adr   = adr_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_dat   = drive_q ? wdata_q : 'z;

  assign ctl.ready  = (state_q == ST_IDLE);
  assign ctl.rvalid = (state_q == ST_RD2);
  assign ctl.rdata  = sram_dat;

endmodule

// File: rtl/sram_ctrl_test.sv
// Nexys2 SRAM exerciser top: button edge detection, address register,
// read-data/LED registers, and the SRAM controller instance.
// Build option: SRAM_WAIT_EN (passed through to sram_ctrl).
module sram_ctrl_test
  import sram_ctrl_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       sw,
  input  logic [2:0]       btn,
  output logic [7:0]       led,
  output logic [ADR_W-1:0] sram_adr,
  inout  wire  [DAT_W-1:0] sram_dat,
  output logic             sram_we_n,
  output logic             sram_oe_n,
  output logic             sram_ce_n,
  output logic             sram_ub,
  output logic             sram_lb
);

  sram_ctrl_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) ctrl_if ();

  logic [2:0]       btn_q, btn_d;
  logic [2:0]       rise;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] data_q, data_d;
  logic [7:0]       led_q, led_d;
  logic             unused_data;

  // Rising-edge requests with btn0 > btn1 > btn2 priority; capture read data
  always_comb begin
    btn_d            = btn;
    rise             = btn & ~btn_q;
    adr_d            = adr_q;
    data_d           = data_q;
    led_d            = led_q;
    ctrl_if.start_wr = 1'b0;
    ctrl_if.start_rd = 1'b0;
    if (rise[BTN_ADR]) begin
      adr_d = ADR_W'(sw);
    end else if (rise[BTN_WR]) begin
      ctrl_if.start_wr = ctrl_if.ready;
    end else if (rise[BTN_RD]) begin
      ctrl_if.start_rd = ctrl_if.ready;
    end
    ctrl_if.adr   = adr_q;
    ctrl_if.wdata = DAT_W'(sw);
    if (ctrl_if.rvalid) begin
      data_d = ctrl_if.rdata;
      led_d  = ctrl_if.rdata[7:0];
    end
  end

  // Button history, address register and read-data/LED registers
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q  <= '0;
      adr_q  <= '0;
      data_q <= '0;
      led_q  <= '0;
    end else begin
      btn_q  <= btn_d;
      adr_q  <= adr_d;
      data_q <= data_d;
      led_q  <= led_d;
    end
  end

  sram_ctrl #(.ADR_W(ADR_W), .DAT_W(DAT_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .ctl       (ctrl_if.slave),
    .sram_adr  (sram_adr),
    .sram_dat  (sram_dat),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n)
  );

  assign led         = led_q;
  assign sram_ub     = 1'b0;
  assign sram_lb     = 1'b0;
  assign unused_data = ^data_q;

endmodule

// File: tb/tb_sram_ctrl_test.sv
// Bench for sram_ctrl_test: access-level reference model compared every
// cycle, plus literal checks at key points. Honours SRAM_WAIT_EN.
module tb_sram_ctrl_test;

  localparam int ADR_W = 19;
  localparam int DAT_W = 16;
`ifdef SRAM_WAIT_EN
  localparam int ACC_LEN = 3;
`else
  localparam int ACC_LEN = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       sw = '0;
  logic [2:0]       btn = '0;
  logic [7:0]       led;
  logic [ADR_W-1:0] sram_adr;
  tri1  [DAT_W-1:0] sram_dat;
  logic             sram_we_n, sram_oe_n, sram_ce_n, sram_ub, sram_lb;
  logic [DAT_W-1:0] rd_val = 16'h00F0;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0, ce_cnt = 0, oe_cnt = 0;
  int b_we, b_ce, b_oe;

  always #5 clk = ~clk;

  sram_ctrl_test #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn       (btn),
    .led       (led),
    .sram_adr  (sram_adr),
    .sram_dat  (sram_dat),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub   (sram_ub),
    .sram_lb   (sram_lb)
  );

  // SRAM device: drives read data while selected and output-enabled
  assign sram_dat = (!sram_oe_n && !sram_ce_n) ? rd_val : 'z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_kind 0 = idle, 1 = write, 2 = read; m_phase = cycle within access
  logic [2:0]       m_prev = '0;
  logic [ADR_W-1:0] m_adr = '0, m_sram_adr = '0;
  logic [7:0]       m_led = '0;
  logic [DAT_W-1:0] m_wdata = '0;
  int               m_kind = 0, m_phase = 0;
  bit               started = 0;

  always @(posedge clk) begin : model
    logic [2:0] r;
    bit idle;
    started = 1;
    if (reset) begin
      m_prev = '0; m_adr = '0; m_sram_adr = '0; m_led = '0;
      m_wdata = '0; m_kind = 0; m_phase = 0;
    end else begin
      r = btn & ~m_prev;
      idle = (m_kind == 0);
      if (!idle) begin
        m_phase++;
        if (m_phase == ACC_LEN) begin
          if (m_kind == 2) m_led = rd_val[7:0];
          m_kind = 0;
          m_phase = 0;
        end
      end
      if (r[0]) begin
        m_adr = ADR_W'(sw);
      end else if (r[1]) begin
        if (idle) begin
          m_kind = 1; m_phase = 0; m_wdata = DAT_W'(sw); m_sram_adr = m_adr;
        end
      end else if (r[2] && idle) begin
        m_kind = 2; m_phase = 0; m_sram_adr = m_adr;
      end
      m_prev = btn;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (started) begin
      check("led", led, m_led);
      check("ce_n", sram_ce_n, (m_kind == 0));
      check("we_n", sram_we_n, !(m_kind == 1 && m_phase < ACC_LEN - 1));
      check("oe_n", sram_oe_n, !(m_kind == 2));
      check("adr", sram_adr, m_sram_adr);
      check("dat", sram_dat, (m_kind == 1) ? m_wdata : (m_kind == 2) ? rd_val : 16'hFFFF);
      check("ub", sram_ub, 1'b0);
      check("lb", sram_lb, 1'b0);
    end
  end

  // Strobe-low cycle counters
  always @(negedge clk) begin
    if (started && !reset) begin
      if (!sram_we_n) we_cnt++;
      if (!sram_ce_n) ce_cnt++;
      if (!sram_oe_n) oe_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic snap();
    b_we = we_cnt; b_ce = ce_cnt; b_oe = oe_cnt;
  endtask

  initial begin
    // Reset for one cycle
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_ce", sram_ce_n, 1'b1);
    check("rst_dat", sram_dat, 16'hFFFF);
    tick(1);

    // Address load held: no strobes
    snap();
    sw = 8'hF0; btn = 3'b001;
    tick(7);
    btn = 3'b000;
    tick(2);
    check("ld_no_ce", ce_cnt - b_ce, 0);
    check("ld_adr_hold", sram_adr, 19'h00000);

    // Held write button: exactly one write of 0x00FF to 0xF0
    snap();
    sw = 8'hFF; btn = 3'b010;
    after_edges(1);
    check("wr1_dat", sram_dat, 16'h00FF);
    check("wr1_adr", sram_adr, 19'h000F0);
    check("wr1_we", sram_we_n, 1'b0);
    tick(6);
    btn = 3'b000;
    tick(3);
    check("wr_we_cyc", we_cnt - b_we, ACC_LEN - 1);
    check("wr_ce_cyc", ce_cnt - b_ce, ACC_LEN);

    // Read: LEDs update one edge after the access completes
    snap();
    btn = 3'b100;
    after_edges(ACC_LEN);
    check("led_pre", led, 8'h00);
    after_edges(1);
    check("led_rd", led, 8'hF0);
    tick(4);
    btn = 3'b000;
    tick(2);
    check("rd_oe_cyc", oe_cnt - b_oe, ACC_LEN);
    check("led_hold", led, 8'hF0);

    // Address and write rising together: address load only
    snap();
    sw = 8'h35; btn = 3'b011;
    tick(3);
    check("tie_no_wr", we_cnt - b_we, 0);
    btn = 3'b000;
    tick(2);
    sw = 8'hA5; btn = 3'b010;
    after_edges(1);
    check("rewr_adr", sram_adr, 19'h00035);
    check("rewr_dat", sram_dat, 16'h00A5);
    tick(4);
    btn = 3'b000;
    tick(2);

    // Write and read rising together, then read edge while busy: no read
    snap();
    sw = 8'h77; btn = 3'b110;
    tick(5);
    btn = 3'b000;
    tick(2);
    sw = 8'h3C; btn = 3'b010;
    tick(1);
    btn = 3'b110;
    tick(4);
    btn = 3'b000;
    tick(2);
    check("rd_dropped", oe_cnt - b_oe, 0);
    check("wr_twice", we_cnt - b_we, 2 * (ACC_LEN - 1));

    // Reset during WR1, then a normal read
    sw = 8'h11; btn = 3'b010;
    tick(1);
    reset = 1'b1; btn = 3'b000;
    after_edges(1);
    check("mid_we", sram_we_n, 1'b1);
    check("mid_ce", sram_ce_n, 1'b1);
    check("mid_dat", sram_dat, 16'hFFFF);
    check("mid_adr", sram_adr, 19'h00000);
    reset = 1'b0;
    rd_val = 16'h1234;
    tick(1);
    btn = 3'b100;
    tick(ACC_LEN + 2);
    check("post_rst_rd", led, 8'h34);
    btn = 3'b000;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_test.md
Name: sram_ctrl_test

Overview:
- Board-level SRAM exerciser for the Nexys2.
- Switches supply an address or write data; three buttons select the operation: load address, write, read.
- Read data is shown on the LEDs.
- Contains a small asynchronous-SRAM controller that generates the active-low strobes and drives or tristates the shared data bus.

Parameters:
- ADR_W, 19, SRAM address width.
- DAT_W, 16, SRAM data bus width; must be at least 8.

Ports:
- clk  input  1  system clock; all logic is single-clock.
- reset  input  1  synchronous, active-high reset.
- sw  input  8  address / write-data source.
- btn  input  3  bit0 = load address, bit1 = write, bit2 = read; active-high, level inputs.
- led  output  8  low byte of the last read data.
- sram_adr  output  ADR_W  SRAM address.
- sram_dat  inout  DAT_W  SRAM data bus; high-Z unless writing.
- sram_we_n  output  1  write enable, active-low.
- sram_oe_n  output  1  output enable, active-low.
- sram_ce_n  output  1  chip enable, active-low.
- sram_ub  output  1  upper-byte enable, active-low; tied 0.
- sram_lb  output  1  lower-byte enable, active-low; tied 0.

Behaviour:
- Reset: adr_reg=0, data_reg=0, led=0, sram_we_n=sram_oe_n=sram_ce_n=1, bus released (Z), FSM=IDLE, button history=0.
- Button handling:
  - Each btn bit is registered once, and a rising edge (current=1, previous=0) produces a one-cycle request.
  - A held button produces exactly one request.
  - Priority when several edges arrive in the same cycle: btn0 > btn1 > btn2. Lower-priority edges are dropped.
- Load address (btn0 edge): adr_reg <= zero-extended sw. Allowed in any FSM state; takes effect on the next access.
- Write (btn1 edge, FSM=IDLE): start a write with data = zero-extended sw.
- Read (btn2 edge, FSM=IDLE): start a read.
- Write/read edges arriving while FSM≠IDLE are ignored; there is no queuing.
- Controller FSM states: IDLE, WR1, WR2, RD1, RD2. All SRAM outputs are registered, so no glitches.
- IDLE: ce_n=1, we_n=1, oe_n=1, bus Z. A request moves to WR1 or RD1 and latches sram_adr from adr_reg.
- WR1: ce_n=0, we_n=0, bus driven with write data. Next state WR2.
- WR2: ce_n=0, we_n=1, bus still driven (data hold). Next state IDLE.
- RD1: ce_n=0, oe_n=0, bus Z. Next state RD2.
- RD2: ce_n=0, oe_n=0. On exit, data_reg <= sram_dat and led <= sram_dat[7:0]. Next state IDLE.
- Latency:
  - Write: 2 cycles from the request cycle to return to IDLE.
  - Read: LEDs update 2 cycles after the request cycle, i.e. 3 clocks after the button rises.
- The bus is never driven while oe_n=0.
- sram_adr holds its value between accesses.
- Synchronous reset mid-access forces IDLE, deasserts all strobes and releases the bus in the same edge.

Optional Feature:
- Macro SRAM_WAIT_EN.
- When defined, a wait state is inserted after WR1 and after RD1 (states WRW and RDW) with the same strobe levels as the preceding state. Each access is lengthened by one cycle, for slow SRAM or fast clocks.
- When undefined, the timing is exactly as in Behaviour.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the FSM state enum (including WRW/RDW);
  - ADR_W/DAT_W defaults;
  - button index constants BTN_ADR=0, BTN_WR=1, BTN_RD=2.
- One sub-module, sram_ctrl, contains the FSM, strobe registers and tristate.
- sram_ctrl interface: start_wr, start_rd, adr, wdata in; rdata, rvalid, ready out.
- The top level does button edge detection, holds the address register and drives the LEDs.

Test Plan:
- Reset asserted for 1 cycle -> led=00, we_n=oe_n=ce_n=1, sram_dat=Z, sram_adr=0.
- sw=F0, btn=001 held 7 cycles -> sram_adr=0x000F0 on the next access; no strobes toggle.
- sw=FF, btn=010 held 7 cycles -> exactly one write: we_n low 1 cycle, ce_n low 2 cycles, sram_dat=0x00FF during WR1/WR2, then Z; adr=0x000F0.
- btn=100, SRAM model returning 0x00F0 while oe_n=0 -> oe_n low 2 cycles, led=F0 three clocks after the press, then held.
- btn=011 rising together -> address load only, no write; a subsequent btn1 re-press writes.
- Reset during WR1 -> next cycle we_n=1, ce_n=1, bus Z, FSM idle; a following read works normally.
